fifo_word_packer: RTL and testbench

//  Read-side consumer of the byte FIFO: pops narrow FIFO entries and packs RATIO of them into one wide word.

---
 rtl/fifo_word_packer.sv | 106 ++++++++++
 tb/tb_fifo_word_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops narrow entries from a show-ahead FIFO read port and
// packs RATIO of them into one wide word presented on a valid/ready stream.
// A flush closes a partially filled word early and reports the filled lanes
// on out_keep.
// Optional build macro PACKER_MSB_FIRST_EN: when defined, the first popped
// entry lands in the most significant lane and out_keep is reversed to match,
// so flushed partial words are left-justified. When undefined, the first
// popped entry lands in the least significant lane.
module fifo_word_packer #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [IN_WIDTH-1:0]       fifo_data,
   input  logic                      fifo_empty,
   output logic                      fifo_rd,
   input  logic                      flush,
   output logic [IN_WIDTH*RATIO-1:0] out_data,
   output logic [RATIO-1:0]          out_keep,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int IDX_W     = $clog2(RATIO);

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   logic [0:0]           state;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     lane;
   logic [OUT_WIDTH-1:0] lane_data;
   logic [RATIO-1:0]     lane_keep;
   logic                 flush_partial;

   // Physical lane that the idx-th popped entry occupies in the output word.
   function automatic logic [IDX_W-1:0] lane_pos(input logic [IDX_W-1:0] i);
`ifdef PACKER_MSB_FIRST_EN
      return LAST_IDX - i;
`else
      return i;
`endif
   endfunction

   // Pop request: only while filling, never from an empty FIFO, and held off
   // on the cycle a non-empty partial word is being closed by flush.
   always_comb begin
      flush_partial = flush && (idx != '0);
      fifo_rd       = resetn && (state == FILL) && !fifo_empty && !flush_partial;
   end

   // Head entry and its keep bit shifted into the lane it will occupy.
   always_comb begin
      lane      = lane_pos(idx);
      lane_data = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, fifo_data} << (lane * IN_WIDTH);
      lane_keep = {{(RATIO-1){1'b0}}, 1'b1} << lane;
   end

   // Fill/hold sequencing; unfilled lanes stay zero because the word is
   // cleared on reset and after every handshake.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= FILL;
         idx       <= '0;
         out_data  <= '0;
         out_keep  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (fifo_rd) begin
                  out_data <= out_data | lane_data;
                  out_keep <= out_keep | lane_keep;
                  if (idx == LAST_IDX) begin
                     idx       <= '0;
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end else if (flush_partial) begin
                  idx       <= '0;
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= FILL;
                  out_valid <= 1'b0;
                  out_keep  <= '0;
                  out_data  <= '0;
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a queue-backed FIFO feeds the packer, a
// lane-list model predicts every cycle's outputs, and directed sequences
// pin known packed words.
module tb_fifo_word_packer;

   localparam int IN_WIDTH = 8;
   localparam int RATIO    = 4;

   logic                      clk = 1'b0;
   logic                      resetn;
   logic [IN_WIDTH-1:0]       fifo_data;
   logic                      fifo_empty;
   logic                      fifo_rd;
   logic                      flush;
   logic [IN_WIDTH*RATIO-1:0] out_data;
   logic [RATIO-1:0]          out_keep;
   logic                      out_valid;
   logic                      out_ready;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   logic [IN_WIDTH-1:0] fq[$];

   // model state: entries accepted into the current word, and whether it is presented
   logic [IN_WIDTH-1:0] m_lanes[RATIO];
   int                  m_n    = 0;
   bit                  m_hold = 1'b0;

   fifo_word_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .fifo_data (fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_rd   (fifo_rd),
      .flush     (flush),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // FIFO head presentation from the queue
   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : '0;
   endtask

   // FIFO pop on the DUT's read strobe
   always @(posedge clk) begin
      if (fifo_rd && fq.size() != 0) void'(fq.pop_front());
   end

   function automatic logic [31:0] model_word();
      logic [31:0] w = '0;
      for (int i = 0; i < m_n; i++) begin
`ifdef PACKER_MSB_FIRST_EN
         w = w | (32'(m_lanes[i]) << ((RATIO - 1 - i) * IN_WIDTH));
`else
         w = w | (32'(m_lanes[i]) << (i * IN_WIDTH));
`endif
      end
      return w;
   endfunction

   function automatic logic [31:0] model_keep();
      logic [31:0] k = '0;
      for (int i = 0; i < m_n; i++) begin
`ifdef PACKER_MSB_FIRST_EN
         k[RATIO - 1 - i] = 1'b1;
`else
         k[i] = 1'b1;
`endif
      end
      return k;
   endfunction

   // per-cycle compare against the model, then advance the model with this cycle's inputs
   always @(negedge clk) begin
      bit exp_rd;
      if (chk_en) begin
         exp_rd = resetn && !m_hold && (fq.size() != 0) && !(flush && m_n != 0);
         check("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
         check("out_valid", 32'(out_valid), 32'(m_hold));
         if (m_hold || m_n == 0) begin
            check("out_data", out_data, model_word());
            check("out_keep", 32'(out_keep), model_keep());
         end
         if (!resetn) begin
            m_n = 0; m_hold = 1'b0;
         end else if (m_hold) begin
            if (out_ready) begin m_hold = 1'b0; m_n = 0; end
         end else if (exp_rd) begin
            m_lanes[m_n] = fq[0];
            m_n++;
            if (m_n == RATIO) m_hold = 1'b1;
         end else if (flush && m_n != 0) begin
            m_hold = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      refresh();
   endtask

   task automatic push(input logic [IN_WIDTH-1:0] v);
      fq.push_back(v);
      refresh();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      if (!out_valid) check({name, "_timeout"}, 32'(out_valid), 32'd1);
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
      refresh();
      step();
      chk_en = 1'b1;
      step();
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_data", out_data, 32'd0);
      resetn = 1'b1;
      step();

      // four entries packed into one word
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      wait_valid("t1");
`ifdef PACKER_MSB_FIRST_EN
      check("t1_data", out_data, 32'h11223344);
`else
      check("t1_data", out_data, 32'h44332211);
`endif
      check("t1_keep", 32'(out_keep), 32'hF);
      step();
      check("t1_one_cycle", 32'(out_valid), 32'd0);
      step();

      // back-pressure: word held for 5 cycles, handshake on the 6th
      out_ready = 1'b0;
      push(8'h55); push(8'h66); push(8'h77); push(8'h88);
      wait_valid("t2");
      for (int i = 0; i < 5; i++) step();
      check("t2_hold_valid", 32'(out_valid), 32'd1);
`ifdef PACKER_MSB_FIRST_EN
      check("t2_hold_data", out_data, 32'h55667788);
`else
      check("t2_hold_data", out_data, 32'h88776655);
`endif
      out_ready = 1'b1;
      step();
      check("t2_released", 32'(out_valid), 32'd0);

      // two pops then flush with the FIFO still non-empty
      push(8'hAA); push(8'hBB);
      step(); step();
      push(8'hCC);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t3_valid", 32'(out_valid), 32'd1);
`ifdef PACKER_MSB_FIRST_EN
      check("t3_data", out_data, 32'hAABB0000);
      check("t3_keep", 32'(out_keep), 32'hC);
`else
      check("t3_data", out_data, 32'h0000BBAA);
      check("t3_keep", 32'(out_keep), 32'h3);
`endif
      check("t3_cc_kept", 32'(fq.size()), 32'd1);
      step(); step(); step();
      flush = 1'b1;
      step();
      flush = 1'b0;
`ifdef PACKER_MSB_FIRST_EN
      check("t3_single", out_data, 32'hCC000000);
`else
      check("t3_single", out_data, 32'h000000CC);
`endif
      step(); step();

      // empty FIFO with flush pulses at lane 0: nothing happens
      for (int i = 0; i < 6; i++) begin
         flush = (i % 2 == 0);
         step();
         check("t4_no_valid", 32'(out_valid), 32'd0);
      end
      flush = 1'b0;

      // reset mid-word discards the partial entries
      push(8'hE1); push(8'hE2);
      step(); step();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check("t5_rst_data", out_data, 32'd0);
      check("t5_rst_keep", 32'(out_keep), 32'd0);
      flush = 1'b1;
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      step();
      flush = 1'b0;
      wait_valid("t5");
`ifdef PACKER_MSB_FIRST_EN
      check("t5_data", out_data, 32'h01020304);
`else
      check("t5_data", out_data, 32'h04030201);
`endif
      step(); step();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
